// File: rtl/pht_update_scheduler_if.sv
// Signal bundle between the PHT update scheduler and its environment (fetch, ALU, PHT macro).
// master = environment side, slave = scheduler side.
interface pht_update_scheduler_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int INDEX_WIDTH   = 8
);
  logic                     i_IMEM_isbranch;
  logic [ADDRESS_WIDTH-1:0] i_IMEM_address;
  logic                     i_ALU_isbranch;
  logic [ADDRESS_WIDTH-1:0] i_ALU_pc;
  logic                     i_ALU_outcome;
  logic                     i_ALU_prediction;
  logic                     o_PHT_en;
  logic                     o_PHT_we;
  logic [INDEX_WIDTH-1:0]   o_PHT_index;
  logic [1:0]               o_PHT_wdata;
  logic [1:0]               i_PHT_rdata;
  logic                     o_valid;
  logic                     o_taken;
  logic                     o_flush;
  logic                     o_full;
  logic                     o_busy;
  logic                     o_overflow;

  modport master (
    output i_IMEM_isbranch, i_IMEM_address,
    output i_ALU_isbranch, i_ALU_pc, i_ALU_outcome, i_ALU_prediction,
    output i_PHT_rdata,
    input  o_PHT_en, o_PHT_we, o_PHT_index, o_PHT_wdata,
    input  o_valid, o_taken, o_flush, o_full, o_busy, o_overflow
  );

  modport slave (
    input  i_IMEM_isbranch, i_IMEM_address,
    input  i_ALU_isbranch, i_ALU_pc, i_ALU_outcome, i_ALU_prediction,
    input  i_PHT_rdata,
    output o_PHT_en, o_PHT_we, o_PHT_index, o_PHT_wdata,
    output o_valid, o_taken, o_flush, o_full, o_busy, o_overflow
  );
endinterface

// File: rtl/pht_update_scheduler.sv
// Single-port PHT arbiter: lookups win the port (fixed 1-cycle response, never stalled); resolved
// branches queue and drain as 3-cycle read-modify-writes when the port is idle; full FIFO drops.
module pht_update_scheduler #(
  parameter int         ADDRESS_WIDTH = 22,
  parameter int         INDEX_WIDTH   = 8,
  parameter int         UPD_DEPTH     = 4,
  parameter logic [1:0] INIT_VALUE    = 2'b01
) (
  input logic                   i_Clk,
  input logic                   i_Reset,
  pht_update_scheduler_if.slave bus
);
  localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CAP, ST_WR} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic                   taken;
  } upd_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [1:0]             ctr_q, ctr_d;
  upd_t                   fifo_q [UPD_DEPTH];
  upd_t                   fifo_d [UPD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   port_read_q, port_read_d;
  logic                   flush_q, flush_d;
  logic                   overflow_q, overflow_d;

  logic                   lookup;
  logic [INDEX_WIDTH-1:0] lookup_idx;
  upd_t                   head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   push;
  logic                   accept;
  logic                   pop;
  logic                   pht_en;
  logic                   pht_we;
  logic [INDEX_WIDTH-1:0] pht_index;
  logic [1:0]             pht_wdata;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign lookup     = bus.i_IMEM_isbranch;
  assign lookup_idx = bus.i_IMEM_address[INDEX_WIDTH-1:0];
  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(UPD_DEPTH));

  // Port sequencing; the port stays quiet while reset is asserted so a half-done RMW is abandoned.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ctr_d      = ctr_q;
    pht_en     = 1'b0;
    pht_we     = 1'b0;
    pht_index  = '0;
    pht_wdata  = 2'b00;
    pop        = 1'b0;
    if (!i_Reset) begin
      if (lookup && state_q != ST_INIT) begin
        pht_en    = 1'b1;
        pht_index = lookup_idx;
      end
      case (state_q)
        ST_INIT: begin
          if (!lookup) begin
            pht_en     = 1'b1;
            pht_we     = 1'b1;
            pht_index  = init_ptr_q;
            pht_wdata  = INIT_VALUE;
            init_ptr_d = init_ptr_q + INDEX_WIDTH'(1);
            if (init_ptr_q == '1) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (!lookup && !fifo_empty) begin
            pht_en    = 1'b1;
            pht_index = head.idx;
            state_d   = ST_CAP;
          end
        end
        ST_CAP: begin
          ctr_d   = bus.i_PHT_rdata;
          state_d = ST_WR;
        end
        ST_WR: begin
          if (!lookup) begin
            pht_en    = 1'b1;
            pht_we    = 1'b1;
            pht_index = head.idx;
            pht_wdata = sat(ctr_q, head.taken);
            pop       = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Update queue: a push into a full queue survives only if the head leaves in the same cycle.
  always_comb begin
    push       = bus.i_ALU_isbranch && !i_Reset;
    accept     = push && (!fifo_full || pop);
    overflow_d = overflow_q || (push && fifo_full && !pop);
    fifo_d     = fifo_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = upd_t'{bus.i_ALU_pc[INDEX_WIDTH-1:0], bus.i_ALU_outcome};
    end
    wr_ptr_d    = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(accept) - CNT_W'(pop);
    valid_d     = lookup;
    port_read_d = lookup && (state_q != ST_INIT);
    flush_d     = bus.i_ALU_isbranch && (bus.i_ALU_outcome != bus.i_ALU_prediction);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      ctr_q       <= 2'b00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      port_read_q <= 1'b0;
      flush_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      ctr_q       <= ctr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      port_read_q <= port_read_d;
      flush_q     <= flush_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.o_PHT_en    = pht_en;
  assign bus.o_PHT_we    = pht_we;
  assign bus.o_PHT_index = pht_index;
  assign bus.o_PHT_wdata = pht_wdata;
  // Lookups taken during INIT never touched the port, so the read data bus is meaningless for them.
  assign bus.o_valid     = valid_q;
  assign bus.o_taken     = valid_q && port_read_q && bus.i_PHT_rdata[1];
  assign bus.o_flush     = flush_q;
  assign bus.o_full      = fifo_full;
  assign bus.o_busy      = (state_q == ST_INIT);
  assign bus.o_overflow  = overflow_q;
endmodule
